// File: rtl/pdm_rx_frontend.sv
// Multi-line PDM microphone front-end: divided pdm_clk_o, dual-edge capture, per-channel bit serialiser.
// Optional build macro PDM_RX_TESTPAT_EN adds cfg_tpat_i to replace captured data by a fixed 1/0 pattern.
module pdm_rx_frontend #(
  parameter int NUM_LINES = 2,
  parameter int DIV_W = 8,
  localparam int NUM_CH = 2 * NUM_LINES,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_W-1:0]     cfg_clkdiv_i,
  input  logic                 cfg_ddr_i,
  input  logic [NUM_CH-1:0]    cfg_ch_mask_i,
  input  logic                 cfg_clr_ovr_i,
`ifdef PDM_RX_TESTPAT_EN
  input  logic                 cfg_tpat_i,
`endif
  output logic                 pdm_clk_o,
  input  logic [NUM_LINES-1:0] pdm_data_i,
  output logic                 bit_data_o,
  output logic [CH_W-1:0]      bit_ch_o,
  output logic                 bit_last_o,
  output logic                 bit_valid_o,
  input  logic                 bit_ready_i,
  output logic                 overrun_o
);

  typedef enum logic {IDLE, SCAN} state_t;

  logic [DIV_W-1:0]     cnt_reg;
  logic                 pdm_clk_reg;
  logic                 toggle, rise_tgl, fall_tgl;
  logic [NUM_LINES-1:0] cap_even, cap_odd, even_reg;
  logic [NUM_CH-1:0]    frame, even_sel, offer_en;
  logic                 offer;

  state_t               state_reg, state_next;
  logic [NUM_CH-1:0]    pend_reg, pend_next, pend_after, shadow_reg, shadow_next, ch_onehot;
  logic                 ovr_set, ovr_reg, xfer;

  logic                 valid_reg, valid_next, data_reg, data_next, last_reg, last_next;
  logic [CH_W-1:0]      ch_reg, ch_next;

  // Divider: the >= compare lets a lowered divisor take effect without wrapping the counter.
  assign toggle   = cfg_en_i && (cnt_reg >= cfg_clkdiv_i);
  assign rise_tgl = toggle && !pdm_clk_reg;
  assign fall_tgl = toggle && pdm_clk_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_en_i) begin
      cnt_reg     <= '0;
      pdm_clk_reg <= 1'b0;
    end else if (toggle) begin
      cnt_reg     <= '0;
      pdm_clk_reg <= ~pdm_clk_reg;
    end else begin
      cnt_reg     <= cnt_reg + 1'b1;
    end
  end

`ifdef PDM_RX_TESTPAT_EN
  assign cap_even = cfg_tpat_i ? '1 : pdm_data_i;
  assign cap_odd  = cfg_tpat_i ? '0 : pdm_data_i;
`else
  assign cap_even = pdm_data_i;
  assign cap_odd  = pdm_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i)         even_reg <= '0;
    else if (rise_tgl) even_reg <= cap_even;
  end

  // Odd channels are taken live on the fall-toggle cycle, which also closes the frame.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    assign frame[2*gi]      = even_reg[gi];
    assign frame[2*gi+1]    = cfg_ddr_i & cap_odd[gi];
    assign even_sel[2*gi]   = 1'b1;
    assign even_sel[2*gi+1] = cfg_ddr_i;
  end

  assign offer_en   = cfg_ch_mask_i & even_sel;
  assign offer      = fall_tgl && (offer_en != '0);
  assign xfer       = valid_reg && bit_ready_i;
  assign ch_onehot  = NUM_CH'(1) << ch_reg;
  assign pend_after = xfer ? (pend_reg & ~ch_onehot) : pend_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_en_i) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         shadow_reg <= '0;
    else if (cfg_en_i) shadow_reg <= shadow_next;
  end

  always_comb begin
    state_next  = state_reg;
    pend_next   = pend_reg;
    shadow_next = shadow_reg;
    ovr_set     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (offer) begin
          state_next  = SCAN;
          pend_next   = offer_en;
          shadow_next = frame;
        end
      end
      SCAN: begin
        pend_next = pend_after;
        // A new frame may only take over in the very cycle the previous one drains.
        if (pend_after == '0) begin
          if (offer) begin
            pend_next   = offer_en;
            shadow_next = frame;
          end else begin
            state_next  = IDLE;
          end
        end else if (offer) begin
          ovr_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    valid_next = (state_next == SCAN);
    ch_next    = '0;
    if (valid_next) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pend_next[i]) ch_next = CH_W'(i);
      end
    end
    data_next = valid_next && shadow_next[ch_next];
    last_next = valid_next && ((pend_next & (pend_next - NUM_CH'(1))) == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_en_i) begin
      valid_reg <= 1'b0;
      data_reg  <= 1'b0;
      ch_reg    <= '0;
      last_reg  <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
      ch_reg    <= ch_next;
      last_reg  <= last_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)              ovr_reg <= 1'b0;
    else if (ovr_set)       ovr_reg <= 1'b1;
    else if (cfg_clr_ovr_i) ovr_reg <= 1'b0;
  end

  assign pdm_clk_o   = pdm_clk_reg;
  assign bit_valid_o = valid_reg;
  assign bit_data_o  = data_reg;
  assign bit_ch_o    = ch_reg;
  assign bit_last_o  = last_reg;
  assign overrun_o   = ovr_reg;

endmodule

// File: tb/tb_pdm_rx_frontend.sv
// Randomised bench for pdm_rx_frontend against a frame-queue reference model.
// Build with PDM_RX_TESTPAT_EN defined to also exercise the test-pattern input.
module tb_pdm_rx_frontend;
  localparam int NUM_LINES = 2;
  localparam int NUM_CH = 2 * NUM_LINES;
  localparam int DIV_W = 8;

  typedef struct {
    int   ch;
    logic d;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, ddr, clr, ready, tpat;
  logic [DIV_W-1:0]     clkdiv;
  logic [NUM_CH-1:0]    mask;
  logic [NUM_LINES-1:0] data;
  logic pdm_clk, bit_data, bit_last, bit_valid, overrun;
  logic [1:0] bit_ch;

  always #5 clk = ~clk;

  pdm_rx_frontend #(.NUM_LINES(NUM_LINES), .DIV_W(DIV_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_en_i      (en),
    .cfg_clkdiv_i  (clkdiv),
    .cfg_ddr_i     (ddr),
    .cfg_ch_mask_i (mask),
    .cfg_clr_ovr_i (clr),
`ifdef PDM_RX_TESTPAT_EN
    .cfg_tpat_i    (tpat),
`endif
    .pdm_clk_o     (pdm_clk),
    .pdm_data_i    (data),
    .bit_data_o    (bit_data),
    .bit_ch_o      (bit_ch),
    .bit_last_o    (bit_last),
    .bit_valid_o   (bit_valid),
    .bit_ready_i   (ready),
    .overrun_o     (overrun)
  );

  int   n_pass = 0;
  int   n_chk = 0;
  int   n_xfer = 0;
  int   ncyc = 0;
  logic [NUM_LINES-1:0] even_m = '0;
  logic ovr_m = 1'b0;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle-in-segment %0d)", tag, act, exp, ncyc);
  endtask

  // Reference: pdm_clk level is a pure function of cycles since enable; each closed
  // frame becomes a list of expected bits, accepted only when nothing is outstanding.
  task automatic model_cycle();
    int   dv;
    logic exp_clk, tog, set;
    logic [NUM_CH-1:0] fb, env;
    exp_t e;
    dv      = int'(clkdiv) + 1;
    exp_clk = ((ncyc / dv) % 2) == 1;
    check("pdm_clk", pdm_clk, exp_clk);
    check("valid", bit_valid, q.size() != 0);
    check("overrun", overrun, ovr_m);
    if (bit_valid === 1'b1 && q.size() != 0) begin
      check("ch", bit_ch, q[0].ch);
      check("data", bit_data, q[0].d);
      check("last", bit_last, q[0].last);
      if (ready) begin
        $display("xfer %0d: ch=%0d data=%0b last=%0b", n_xfer, bit_ch, bit_data, bit_last);
        n_xfer++;
        void'(q.pop_front());
      end
    end
    set = 1'b0;
    tog = !rst && en && (((ncyc + 1) % dv) == 0);
    if (tog && !exp_clk) begin
      for (int l = 0; l < NUM_LINES; l++) even_m[l] = tpat ? 1'b1 : data[l];
    end
    if (tog && exp_clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (c % 2 == 0) fb[c] = even_m[c/2];
        else            fb[c] = ddr && !tpat && data[c/2];
        env[c] = mask[c] && (ddr || (c % 2 == 0));
      end
      if (env != '0) begin
        if (q.size() == 0) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (env[c]) begin
              e.ch = c;
              e.d = fb[c];
              e.last = ((env >> (c + 1)) == '0);
              q.push_back(e);
            end
          end
        end else begin
          set = 1'b1;
        end
      end
    end
    if (rst)      ovr_m = 1'b0;
    else if (set) ovr_m = 1'b1;
    else if (clr) ovr_m = 1'b0;
    if (rst || !en) begin
      q.delete();
      ncyc = 0;
    end else begin
      ncyc++;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int rpct, input bit rdata, input bit rcfg);
    for (int i = 0; i < n; i++) begin
      if (rdata) data = NUM_LINES'($urandom_range(0, (1 << NUM_LINES) - 1));
      ready = ($urandom_range(0, 99) < rpct);
      if (rcfg) begin
        if ($urandom_range(0, 15) == 0) begin
          mask = NUM_CH'($urandom);
          ddr  = 1'($urandom);
        end
        clr = ($urandom_range(0, 23) == 0);
      end
      run_cycle();
    end
    clr = 1'b0;
  endtask

  task automatic set_div(input int newd);
    en = 1'b0;
    run_cycle();
    clkdiv = DIV_W'(newd);
    run_cycle();
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clkdiv = 8'd1; ddr = 1'b1; mask = 4'hF;
    clr = 1'b0; ready = 1'b1; data = '0; tpat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_pdm_clk", pdm_clk, 1'b0);
    check("rst_valid", bit_valid, 1'b0);
    check("rst_data", bit_data, 1'b0);
    check("rst_ch", bit_ch, 2'd0);
    check("rst_last", bit_last, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    @(posedge clk);
    #1;
    run_cycle();
    rst = 1'b0;

    // Fixed lines, ready high, full DDR frame every 4 cycles.
    en = 1'b1;
    data = 2'b01;
    run(40, 100, 1'b0, 1'b0);
    // Even channels only.
    ddr = 1'b0;
    run(40, 100, 1'b1, 1'b0);
    // Single channel with stalling consumer.
    ddr = 1'b1;
    mask = 4'b0100;
    set_div(7);
    run(120, 25, 1'b1, 1'b0);
    // Overload at clk/2, then clear overrun under a sustainable load.
    mask = 4'hF;
    set_div(0);
    run(8, 0, 1'b1, 1'b0);
    run(10, 100, 1'b1, 1'b0);
    ddr = 1'b0;
    run(6, 100, 1'b1, 1'b0);
    clr = 1'b1;
    run_cycle();
    clr = 1'b0;
    run(20, 100, 1'b1, 1'b0);
    // Disable at random points mid-frame, then re-enable.
    ddr = 1'b1;
    set_div(3);
    for (int k = 0; k < 6; k++) begin
      run($urandom_range(9, 30), 80, 1'b1, 1'b0);
      en = 1'b0;
      run_cycle();
      en = 1'b1;
    end
    run(20, 100, 1'b1, 1'b0);
    // Reset while a frame is being scanned.
    run($urandom_range(5, 12), 50, 1'b1, 1'b0);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    run(30, 100, 1'b1, 1'b0);
    // Random configurations and consumer behaviour.
    for (int s = 0; s < 10; s++) begin
      mask = NUM_CH'($urandom);
      ddr  = 1'($urandom);
      set_div($urandom_range(0, 5));
      run($urandom_range(30, 120), $urandom_range(30, 100), 1'b1, 1'b1);
    end
`ifdef PDM_RX_TESTPAT_EN
    tpat = 1'b1;
    mask = 4'hF;
    ddr = 1'b1;
    set_div(1);
    run(40, 100, 1'b1, 1'b0);
    tpat = 1'b0;
    run(20, 100, 1'b1, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
